// File: rtl/forward_unit_pkg.sv
// Shared types for the forwarding/hazard unit: operand select codes,
// the stall FSM state encoding and the per-stage shadow entry.
package forward_unit_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rw;
    logic       regwrite;
    logic       memtoreg;
    logic       memacc;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '0;

endpackage

// File: rtl/forward_unit_fwd_cmp.sv
// Computes one EX-operand select from a source register number and the
// EX/MEM shadow entries; the EX match outranks the MEM match.
module fwd_cmp
  import forward_unit_pkg::*;
(
  input  logic   [4:0] i_src,
  input  entry_t       i_ex,
  input  entry_t       i_mem,
  output logic   [1:0] o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_unused;

  // r0 is hardwired zero, so a write to it never produces a usable value
  assign w_ex_hit  = i_ex.valid  && i_ex.regwrite  && (i_ex.rw  == i_src) && (i_src != 5'd0);
  assign w_mem_hit = i_mem.valid && i_mem.regwrite && (i_mem.rw == i_src) && (i_src != 5'd0);

  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_WB;
    end
  end

  assign w_unused = &{1'b0, i_ex.memtoreg, i_ex.memacc, i_mem.memtoreg, i_mem.memacc};

endmodule

// File: rtl/forward_unit.sv
// Pipeline forwarding and hazard unit: shadows the EX/MEM/WB stages, issues
// registered operand selects, load-use stalls and memory-wait freezes.
module forward_unit
  import forward_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rw,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             flush,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_count
);

  entry_t           r_ex;
  entry_t           r_mem;
  entry_t           r_wb;
  state_t           r_state;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_count;

  entry_t     w_id_entry;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_mem_busy;
  logic       w_load_use;
  logic       w_stall;
  logic       w_unused;

  always_comb begin
    w_id_entry = ENTRY_BUBBLE;
    if (id_valid && !flush) begin
      w_id_entry.valid    = 1'b1;
      w_id_entry.rw       = id_rw;
      w_id_entry.regwrite = id_regwrite;
      w_id_entry.memtoreg = id_memtoreg;
      w_id_entry.memacc   = id_memtoreg | id_memwrite;
    end
  end

  assign w_mem_busy = r_mem.valid && r_mem.memacc && !mem_ready;
  assign w_load_use = id_valid && !flush && r_ex.valid && r_ex.memtoreg &&
                      (r_ex.rw != 5'd0) && ((r_ex.rw == id_rs) || (r_ex.rw == id_rt));
  assign w_stall    = w_load_use && !w_mem_busy;

  fwd_cmp u_cmp_a (
    .i_src (id_rs),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel_a)
  );

  fwd_cmp u_cmp_b (
    .i_src (id_rt),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex          <= ENTRY_BUBBLE;
      r_mem         <= ENTRY_BUBBLE;
      r_wb          <= ENTRY_BUBBLE;
      r_fwd_a       <= FWD_RF;
      r_fwd_b       <= FWD_RF;
      r_state       <= ST_RUN;
      r_stall_count <= '0;
    end else begin
      if (w_stall) begin
        r_ex    <= ENTRY_BUBBLE;
        r_mem   <= r_ex;
        r_wb    <= r_mem;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else if (!w_mem_busy) begin
        r_ex    <= w_id_entry;
        r_mem   <= r_ex;
        r_wb    <= r_mem;
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end

      case (r_state)
        ST_RUN: begin
          if (w_mem_busy) begin
            r_state <= ST_MEM_WAIT;
          end else if (w_load_use) begin
            r_state <= ST_LOAD_STALL;
          end
        end
        ST_LOAD_STALL: r_state <= ST_RUN;
        ST_MEM_WAIT:   if (mem_ready) r_state <= ST_RUN;
        default:       r_state <= ST_RUN;
      endcase

      if ((w_stall || w_mem_busy) && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign fwd_a       = r_fwd_a;
  assign fwd_b       = r_fwd_b;
  assign stall       = w_stall;
  assign freeze      = w_mem_busy;
  assign stall_count = r_stall_count;

  // The WB shadow is tracked so the pipeline model is complete; nothing reads it
  assign w_unused = &{1'b0, r_wb, r_ex.memacc, r_mem.memtoreg};

endmodule

// File: tb/tb_forward_unit.sv
// Directed bench for forward_unit: forwarding, load-use stall, memory freeze,
// r0/flush corner cases, async reset and counter saturation (CNT_W = 4).
module tb_forward_unit;
  import forward_unit_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_rw;
  logic             id_regwrite, id_memtoreg, id_memwrite;
  logic             flush;
  logic             mem_ready;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, freeze;
  logic [CNT_W-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  forward_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rw       (id_rw),
    .id_regwrite (id_regwrite),
    .id_memtoreg (id_memtoreg),
    .id_memwrite (id_memwrite),
    .flush       (flush),
    .mem_ready   (mem_ready),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .freeze      (freeze),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rw, input logic rwr, input logic m2r,
                        input logic mwr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rw       = rw;
    id_regwrite = rwr;
    id_memtoreg = m2r;
    id_memwrite = mwr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-22s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("reset_fwd_a",  32'(fwd_a), 32'(FWD_RF));
    chk("reset_fwd_b",  32'(fwd_b), 32'(FWD_RF));
    chk("reset_stall",  32'(stall), 32'd0);
    chk("reset_freeze", 32'(freeze), 32'd0);
    chk("reset_count",  32'(stall_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // add r3 then sub using rs = 3
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
    settle();
    chk("ex_fwd_no_stall", 32'(stall), 32'd0);
    tick();
    chk("ex_fwd_a", 32'(fwd_a), 32'(FWD_EXMEM));
    chk("ex_fwd_b", 32'(fwd_b), 32'(FWD_RF));

    // add r3, nop, use rt = 3
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    chk("wb_fwd_b", 32'(fwd_b), 32'(FWD_WB));
    chk("wb_fwd_a", 32'(fwd_a), 32'(FWD_RF));

    // r3 written in both EX and MEM: EX wins
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    chk("prio_fwd_b", 32'(fwd_b), 32'(FWD_EXMEM));
    chk("prio_fwd_a", 32'(fwd_a), 32'(FWD_RF));

    // lw r5 then use rs = 5
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    settle();
    chk("lu_stall_on", 32'(stall), 32'd1);
    chk("lu_freeze_off", 32'(freeze), 32'd0);
    tick();
    chk("lu_state", 32'(dut.r_state), 32'(ST_LOAD_STALL));
    chk("lu_stall_off", 32'(stall), 32'd0);
    chk("lu_bubble_fwd_a", 32'(fwd_a), 32'(FWD_RF));
    chk("lu_count", 32'(stall_count), 32'd1);
    tick();
    chk("lu_fwd_a", 32'(fwd_a), 32'(FWD_WB));
    chk("lu_count_after", 32'(stall_count), 32'd1);

    // lw r6 sits in MEM while memory is not ready for 3 cycles
    set_id(1'b1, 5'd1, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_frz_fwd_a", 32'(fwd_a), 32'(FWD_WB));
    set_id(1'b1, 5'd10, 5'd6, 5'd11, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b0;
    settle();
    chk("frz_on", 32'(freeze), 32'd1);
    chk("frz_no_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz_hold_fwd_a_%0d", i), 32'(fwd_a), 32'(FWD_WB));
      chk($sformatf("frz_hold_fwd_b_%0d", i), 32'(fwd_b), 32'(FWD_RF));
      chk($sformatf("frz_count_%0d", i), 32'(stall_count), 32'(2 + i));
      chk($sformatf("frz_mem_rw_%0d", i), 32'(dut.r_mem.rw), 32'd6);
    end
    chk("frz_state", 32'(dut.r_state), 32'(ST_MEM_WAIT));
    mem_ready = 1'b1;
    settle();
    chk("frz_release", 32'(freeze), 32'd0);
    tick();
    chk("post_frz_fwd_a", 32'(fwd_a), 32'(FWD_EXMEM));
    chk("post_frz_fwd_b", 32'(fwd_b), 32'(FWD_WB));
    chk("post_frz_count", 32'(stall_count), 32'd4);

    // load into r0 then read r0: never forwarded, never stalls
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    settle();
    chk("r0_no_stall", 32'(stall), 32'd0);
    tick();
    chk("r0_fwd_a", 32'(fwd_a), 32'(FWD_RF));
    chk("r0_fwd_b", 32'(fwd_b), 32'(FWD_RF));

    // flush coinciding with a load-use hazard
    set_id(1'b1, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    settle();
    chk("flush_no_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_ex_bubble", 32'(dut.r_ex.valid), 32'd0);
    chk("flush_count", 32'(stall_count), 32'd4);

    // reset pulsed during MEM_WAIT
    set_id(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    mem_ready = 1'b0;
    settle();
    chk("rstw_freeze_on", 32'(freeze), 32'd1);
    tick();
    chk("rstw_state_wait", 32'(dut.r_state), 32'(ST_MEM_WAIT));
    rst_n = 1'b0;
    settle();
    chk("rstw_freeze", 32'(freeze), 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_fwd_a", 32'(fwd_a), 32'd0);
    chk("rstw_fwd_b", 32'(fwd_b), 32'd0);
    chk("rstw_count", 32'(stall_count), 32'd0);
    chk("rstw_state", 32'(dut.r_state), 32'(ST_RUN));
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b1;

    // continuous freeze saturates the 4-bit counter at 15
    set_id(1'b1, 5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_count_14", 32'(stall_count), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_count_15", 32'(stall_count), 32'd15);
    chk("sat_freeze", 32'(freeze), 32'd1);
    mem_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
